gpio_regs: RTL and testbench

Memory-mapped register front end for the 28-pin GPIO bank. Sits directly upstream of the pin-level GPIO block: it holds the direction and output-data registers that drive that block's `dir`/`out_data` inputs, and consumes its registered `in_data` for readback and edge-triggered interrupts. Exposes a simple single-cycle-request / one-cycle-ack bus slave to the CPU.

---
 rtl/gpio_regs.sv | 174 +++++++++++++++++
 tb/tb_gpio_regs.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_regs.sv
// gpio_regs: memory-mapped register front end for the GPIO bank.
// Holds DIR/OUT, reads back the pin inputs, and (optionally) latches
// edge events into an interrupt status register.
// Optional feature macro: GPIO_IRQ_EN (edge detect, IRQ_RISE/IRQ_FALL/
// IRQ_STAT registers and irq). Without it those offsets act as unmapped
// and irq is tied low.
module gpio_regs #(
  parameter int N = 28
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bus_valid,
  input  logic          bus_we,
  input  logic [5:0]    bus_addr,
  input  logic [31:0]   bus_wdata,
  output logic [31:0]   bus_rdata,
  output logic          bus_ack,
  output logic [N-1:0]  gpio_dir,
  output logic [N-1:0]  gpio_out,
  input  logic [N-1:0]  gpio_in,
  output logic          irq
);

  // Register word indices (bus_addr[5:2])
  localparam logic [3:0] A_DIR      = 4'h0;
  localparam logic [3:0] A_OUT      = 4'h1;
  localparam logic [3:0] A_IN       = 4'h2;
  localparam logic [3:0] A_OUT_SET  = 4'h3;
  localparam logic [3:0] A_OUT_CLR  = 4'h4;
  localparam logic [3:0] A_OUT_TGL  = 4'h5;
`ifdef GPIO_IRQ_EN
  localparam logic [3:0] A_IRQ_RISE = 4'h6;
  localparam logic [3:0] A_IRQ_FALL = 4'h7;
  localparam logic [3:0] A_IRQ_STAT = 4'h8;
`endif

  logic          wr_en;
  logic          rd_en;
  logic [3:0]    sel;
  logic [N-1:0]  wdata;

  assign wr_en = bus_valid & bus_we;
  assign rd_en = bus_valid & ~bus_we;
  assign sel   = bus_addr[5:2];
  assign wdata = bus_wdata[N-1:0];

  // Byte-lane bits of the address and write-data bits above N carry no meaning.
  logic unused_addr;
  assign unused_addr = ^bus_addr[1:0];

  genvar gi;
  generate
    if (N < 32) begin : g_unused_wdata
      logic unused_wdata;
      assign unused_wdata = ^bus_wdata[31:N];
    end
  endgenerate

  logic [N-1:0]  dir_q, dir_d;
  logic [N-1:0]  out_q, out_d;
  logic          ack_q;
  logic [31:0]   rdata_q, rdata_d;
  logic [N-1:0]  rd_val;

`ifdef GPIO_IRQ_EN
  logic [N-1:0]  in_prev_q;
  logic [N-1:0]  rise_q, rise_d;
  logic [N-1:0]  fall_q, fall_d;
  logic [N-1:0]  stat_q, stat_d;
  logic [N-1:0]  w1c_mask;
  logic [N-1:0]  edge_evt;
  logic          irq_q;

  // Per-line edge detection; lines configured as outputs never raise events.
  generate
    for (gi = 0; gi < N; gi++) begin : g_edge
      assign edge_evt[gi] = ~dir_q[gi] &
                            (( gpio_in[gi] & ~in_prev_q[gi] & rise_q[gi]) |
                             (~gpio_in[gi] &  in_prev_q[gi] & fall_q[gi]));
    end
  endgenerate

  // Interrupt register next state; a fresh edge beats a same-cycle W1C.
  always_comb begin
    rise_d   = rise_q;
    fall_d   = fall_q;
    w1c_mask = '0;
    if (wr_en) begin
      case (sel)
        A_IRQ_RISE: rise_d   = wdata;
        A_IRQ_FALL: fall_d   = wdata;
        A_IRQ_STAT: w1c_mask = wdata;
        default: ;
      endcase
    end
    stat_d = (stat_q & ~w1c_mask) | edge_evt;
  end

  // Interrupt state registers; irq follows the updated status directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_prev_q <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      stat_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      in_prev_q <= gpio_in;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      stat_q    <= stat_d;
      irq_q     <= |stat_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // DIR/OUT next state, including the set/clear/toggle aliases of OUT.
  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    if (wr_en) begin
      case (sel)
        A_DIR:     dir_d = wdata;
        A_OUT:     out_d = wdata;
        A_OUT_SET: out_d = out_q | wdata;
        A_OUT_CLR: out_d = out_q & ~wdata;
        A_OUT_TGL: out_d = out_q ^ wdata;
        default: ;
      endcase
    end
  end

  // Read mux; write-only, unmapped and write cycles all return zero.
  always_comb begin
    rd_val = '0;
    case (sel)
      A_DIR:      rd_val = dir_q;
      A_OUT:      rd_val = out_q;
      A_IN:       rd_val = gpio_in;
`ifdef GPIO_IRQ_EN
      A_IRQ_RISE: rd_val = rise_q;
      A_IRQ_FALL: rd_val = fall_q;
      A_IRQ_STAT: rd_val = stat_q;
`endif
      default:    rd_val = '0;
    endcase
    rdata_d = rd_en ? 32'(rd_val) : 32'h0;
  end

  // Bus-side registers: ack one cycle after each request, data captured with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q   <= '0;
      out_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      dir_q   <= dir_d;
      out_q   <= out_d;
      ack_q   <= bus_valid;
      rdata_q <= rdata_d;
    end
  end

  assign bus_ack   = ack_q;
  assign bus_rdata = rdata_q;
  assign gpio_dir  = dir_q;
  assign gpio_out  = out_q;

endmodule

// File: tb/tb_gpio_regs.sv
// Testbench for gpio_regs: directed vector table, hand-written interrupt
// sequences and a randomized phase checked against a behavioural model.
module tb_gpio_regs;
  localparam int N = 28;
  localparam logic [31:0] MASK = 32'((64'd1 << N) - 64'd1);
`ifdef GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          bus_valid;
  logic          bus_we;
  logic [5:0]    bus_addr;
  logic [31:0]   bus_wdata;
  logic [31:0]   bus_rdata;
  logic          bus_ack;
  logic [N-1:0]  gpio_dir;
  logic [N-1:0]  gpio_out;
  logic [N-1:0]  gpio_in;
  logic          irq;

  gpio_regs #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .gpio_dir  (gpio_dir),
    .gpio_out  (gpio_out),
    .gpio_in   (gpio_in),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Behavioural model: registers held as plain words, updated once per cycle.
  logic [31:0] m_dir, m_out, m_rise, m_fall, m_stat, m_prev, m_rdata;
  bit          m_ack, m_irq;

  task automatic model_step(input bit rst, input bit v, input bit we,
                            input logic [5:0] a, input logic [31:0] wd,
                            input logic [31:0] gin);
    int          idx;
    logic [31:0] w, g, rd, ev, clr;
    idx = int'(a[5:2]);
    w   = wd & MASK;
    g   = gin & MASK;
    rd  = 32'h0;
    clr = 32'h0;
    if (rst) begin
      m_dir = 0; m_out = 0; m_rise = 0; m_fall = 0; m_stat = 0; m_prev = 0;
      m_rdata = 0; m_ack = 0; m_irq = 0;
      return;
    end
    if (v && !we) begin
      case (idx)
        0: rd = m_dir;
        1: rd = m_out;
        2: rd = g;
        6: rd = IRQ_EN ? m_rise : 32'h0;
        7: rd = IRQ_EN ? m_fall : 32'h0;
        8: rd = IRQ_EN ? m_stat : 32'h0;
        default: rd = 32'h0;
      endcase
    end
    m_ack   = v;
    m_rdata = rd;
    ev = IRQ_EN ? (((g & ~m_prev & m_rise) | (~g & m_prev & m_fall)) & ~m_dir & MASK) : 32'h0;
    if (v && we) begin
      case (idx)
        0: m_dir = w;
        1: m_out = w;
        3: m_out = m_out | w;
        4: m_out = m_out & ~w;
        5: m_out = m_out ^ w;
        6: if (IRQ_EN) m_rise = w;
        7: if (IRQ_EN) m_fall = w;
        8: clr = w;
        default: ;
      endcase
    end
    m_stat = (m_stat & ~clr) | ev;
    m_irq  = (m_stat != 0);
    m_prev = IRQ_EN ? g : 32'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cyc %0d %s: got %h expected %h", cyc, name, act, exp);
    end
  endtask

  // One bus cycle: drive at the falling edge, step the model at the rising edge.
  task automatic cycle(input bit rst, input bit v, input bit we, input logic [5:0] a,
                       input logic [31:0] wd, input logic [31:0] gin);
    @(negedge clk);
    reset     = rst;
    bus_valid = v;
    bus_we    = we;
    bus_addr  = a;
    bus_wdata = wd;
    gpio_in   = gin[N-1:0];
    @(posedge clk);
    model_step(rst, v, we, a, wd, gin);
    #1;
    cyc++;
  endtask

  typedef struct {
    bit          rst;
    bit          v;
    bit          we;
    logic [5:0]  a;
    logic [31:0] wd;
    logic [31:0] gin;
    bit          e_ack;
    logic [31:0] e_rd;
    logic [31:0] e_dir;
    logic [31:0] e_out;
  } vec_t;

  function automatic vec_t mk(bit rst, bit v, bit we, logic [5:0] a, logic [31:0] wd,
                              logic [31:0] gin, bit e_ack, logic [31:0] e_rd,
                              logic [31:0] e_dir, logic [31:0] e_out);
    vec_t t;
    t.rst = rst; t.v = v; t.we = we; t.a = a; t.wd = wd; t.gin = gin;
    t.e_ack = e_ack; t.e_rd = e_rd; t.e_dir = e_dir; t.e_out = e_out;
    return t;
  endfunction

  vec_t tbl[19];

  initial begin
    logic [31:0] g;
    logic [5:0]  ra;
    bit          rv, rwe, rrst;

    reset = 1'b1; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; gpio_in = '0;

    //            rst v we addr   wdata         gin           ack rdata         dir           out
    tbl[0]  = mk(1, 0, 0, 6'h00, 32'h0,        32'h0,        0, 32'h0,        32'h0,        32'h0);
    tbl[1]  = mk(0, 1, 0, 6'h00, 32'h0,        32'h0A5A5A5A, 1, 32'h0,        32'h0,        32'h0);
    tbl[2]  = mk(0, 1, 0, 6'h04, 32'h0,        32'h0A5A5A5A, 1, 32'h0,        32'h0,        32'h0);
    tbl[3]  = mk(0, 1, 0, 6'h08, 32'h0,        32'h0A5A5A5A, 1, 32'h0A5A5A5A, 32'h0,        32'h0);
    tbl[4]  = mk(0, 0, 0, 6'h08, 32'h0,        32'h0,        0, 32'h0,        32'h0,        32'h0);
    tbl[5]  = mk(0, 1, 1, 6'h04, 32'h00F00000, 32'h0,        1, 32'h0,        32'h0,        32'h00F00000);
    tbl[6]  = mk(0, 1, 1, 6'h0C, 32'h000000F3, 32'h0,        1, 32'h0,        32'h0,        32'h00F000F3);
    tbl[7]  = mk(0, 1, 1, 6'h10, 32'h00F00001, 32'h0,        1, 32'h0,        32'h0,        32'h000000F2);
    tbl[8]  = mk(0, 1, 1, 6'h14, 32'h00000003, 32'h0,        1, 32'h0,        32'h0,        32'h000000F1);
    tbl[9]  = mk(0, 1, 0, 6'h0C, 32'h0,        32'h0,        1, 32'h0,        32'h0,        32'h000000F1);
    tbl[10] = mk(0, 1, 1, 6'h00, 32'hFFFFFFFF, 32'h0,        1, 32'h0,        32'h0FFFFFFF, 32'h000000F1);
    tbl[11] = mk(0, 1, 0, 6'h01, 32'h0,        32'h0,        1, 32'h0FFFFFFF, 32'h0FFFFFFF, 32'h000000F1);
    tbl[12] = mk(0, 1, 1, 6'h3C, 32'hFFFFFFFF, 32'h0,        1, 32'h0,        32'h0FFFFFFF, 32'h000000F1);
    tbl[13] = mk(0, 1, 0, 6'h3C, 32'h0,        32'h0,        1, 32'h0,        32'h0FFFFFFF, 32'h000000F1);
    tbl[14] = mk(0, 1, 0, 6'h07, 32'h0,        32'h0,        1, 32'h000000F1, 32'h0FFFFFFF, 32'h000000F1);
    tbl[15] = mk(0, 1, 0, 6'h00, 32'h0,        32'h0,        1, 32'h0FFFFFFF, 32'h0FFFFFFF, 32'h000000F1);
    tbl[16] = mk(1, 1, 1, 6'h04, 32'h000000FF, 32'h0,        0, 32'h0,        32'h0,        32'h0);
    tbl[17] = mk(0, 0, 0, 6'h00, 32'h0,        32'h0,        0, 32'h0,        32'h0,        32'h0);
    tbl[18] = mk(0, 1, 0, 6'h04, 32'h0,        32'h0,        1, 32'h0,        32'h0,        32'h0);

    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].rst, tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].gin);
      $display("vec %0d: ack=%0b rdata=%h dir=%h out=%h", i, bus_ack, bus_rdata, gpio_dir, gpio_out);
      chk($sformatf("vec%0d_ack", i),   32'(bus_ack),  32'(tbl[i].e_ack));
      chk($sformatf("vec%0d_rdata", i), bus_rdata,     tbl[i].e_rd);
      chk($sformatf("vec%0d_dir", i),   32'(gpio_dir), tbl[i].e_dir);
      chk($sformatf("vec%0d_out", i),   32'(gpio_out), tbl[i].e_out);
      chk($sformatf("vec%0d_irq", i),   32'(irq),      32'h0);
    end

    // Rising-edge interrupt, edge vs same-cycle W1C, then a plain W1C.
    cycle(0, 1, 1, 6'h18, 32'h1, 32'h0);
    cycle(0, 0, 0, 6'h00, 32'h0, 32'h1);
    $display("irq rise: irq=%0b", irq);
    chk("rise_irq", 32'(irq), 32'(IRQ_EN));
    cycle(0, 1, 0, 6'h20, 32'h0, 32'h1);
    $display("read stat: rdata=%h", bus_rdata);
    chk("rise_stat", bus_rdata, IRQ_EN ? 32'h1 : 32'h0);
    cycle(0, 0, 0, 6'h00, 32'h0, 32'h0);
    cycle(0, 1, 1, 6'h20, 32'h1, 32'h1);
    $display("edge+w1c: irq=%0b", irq);
    chk("edge_wins_irq", 32'(irq), 32'(IRQ_EN));
    cycle(0, 1, 0, 6'h20, 32'h0, 32'h1);
    chk("edge_wins_stat", bus_rdata, IRQ_EN ? 32'h1 : 32'h0);
    cycle(0, 1, 1, 6'h20, 32'h1, 32'h1);
    $display("w1c: irq=%0b", irq);
    chk("w1c_irq", 32'(irq), 32'h0);
    cycle(0, 1, 0, 6'h20, 32'h0, 32'h1);
    chk("w1c_stat", bus_rdata, 32'h0);

    // Output-configured line ignores falling edges.
    cycle(0, 1, 1, 6'h00, 32'h8, 32'h1);
    cycle(0, 1, 1, 6'h1C, 32'h8, 32'h1);
    cycle(0, 0, 0, 6'h00, 32'h0, 32'h9);
    cycle(0, 0, 0, 6'h00, 32'h0, 32'h1);
    cycle(0, 0, 0, 6'h00, 32'h0, 32'h9);
    cycle(0, 1, 0, 6'h20, 32'h0, 32'h9);
    $display("dir-masked fall: irq=%0b stat=%h dir=%h", irq, bus_rdata, gpio_dir);
    chk("dirmask_irq", 32'(irq), 32'h0);
    chk("dirmask_stat", bus_rdata, 32'h0);
    chk("dirmask_dir", 32'(gpio_dir), 32'h8);

    // Falling edge as input, then clearing the enable leaves status pending.
    cycle(0, 1, 1, 6'h00, 32'h0, 32'h9);
    cycle(0, 0, 0, 6'h00, 32'h0, 32'h1);
    chk("fall_irq", 32'(irq), 32'(IRQ_EN));
    cycle(0, 1, 1, 6'h1C, 32'h0, 32'h1);
    cycle(0, 1, 0, 6'h20, 32'h0, 32'h1);
    $display("mask clear: irq=%0b stat=%h", irq, bus_rdata);
    chk("maskclr_irq", 32'(irq), 32'(IRQ_EN));
    chk("maskclr_stat", bus_rdata, IRQ_EN ? 32'h8 : 32'h0);

    // Randomized traffic against the model.
    cycle(1, 0, 0, 6'h00, 32'h0, 32'h0);
    g = 32'h0;
    for (int i = 0; i < 600; i++) begin
      rrst = ($urandom_range(0, 99) == 0);
      rv   = ($urandom_range(0, 3) != 0);
      rwe  = $urandom_range(0, 1) == 1;
      ra   = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0) g = g ^ ($urandom & $urandom & MASK);
      cycle(rrst, rv, rwe, ra, $urandom, g);
      $display("rnd %0d: rst=%0b v=%0b we=%0b a=%h ack=%0b rdata=%h dir=%h out=%h irq=%0b",
               i, rrst, rv, rwe, ra, bus_ack, bus_rdata, gpio_dir, gpio_out, irq);
      chk("rnd_ack",   32'(bus_ack),  32'(m_ack));
      chk("rnd_rdata", bus_rdata,     m_rdata);
      chk("rnd_dir",   32'(gpio_dir), m_dir);
      chk("rnd_out",   32'(gpio_out), m_out);
      chk("rnd_irq",   32'(irq),      32'(m_irq));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
